sw_tile_solver_param: RTL and testbench

Parametrised Smith-Waterman tile engine. It is the next generation of the fixed 16x16 tile solver.
- Computes an N x N local-alignment score tile as an anti-diagonal wavefront, one anti-diagonal per clock.
- Match, mismatch and gap scores and the score width are parameters; results saturate.
- Exports last row, last column, corner cell and the tile maximum with its position, so the tile scheduler can chain tiles across the full matrix.

---
 rtl/sw_tile_solver_param.sv | 272 +++++++++++++++++++++++++++
 tb/tb_sw_tile_solver_param.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_tile_solver_param.sv
// Parametrised Smith-Waterman tile engine: computes an N x N local-alignment
// score tile one anti-diagonal per clock and exports the last row, the last
// column, the corner cell and the tile maximum with its position.
// Optional feature macro SW_DIR_EN adds the per-cell traceback direction
// output dirMatrix.
module sw_tile_solver_param #(
    parameter int unsigned N        = 16,
    parameter int unsigned SCORE_W  = 8,
    parameter int unsigned TILE_W   = 4,
    parameter int unsigned MATCH    = 2,
    parameter int unsigned MISMATCH = 1,
    parameter int unsigned GAP      = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [TILE_W-1:0]       tileNum,
    input  logic [2*N-1:0]          S1,
    input  logic [2*N-1:0]          S2,
    input  logic [N*SCORE_W-1:0]    firstRow,
    input  logic [N*SCORE_W-1:0]    firstCol,
    input  logic [SCORE_W-1:0]      diagonalCell,
    output logic [N*SCORE_W-1:0]    lastRow,
    output logic [N*SCORE_W-1:0]    lastCol,
    output logic [SCORE_W-1:0]      diagonalOut,
    output logic [SCORE_W-1:0]      maxValue,
    output logic [$clog2(N)-1:0]    maxRow,
    output logic [$clog2(N)-1:0]    maxCol,
    output logic [TILE_W-1:0]       tileNumOut,
    output logic                    busy,
    output logic                    valid
`ifdef SW_DIR_EN
    ,
    output logic [2*N*N-1:0]        dirMatrix
`endif
);

    localparam int          NI = int'(N);
    localparam int unsigned RW = $clog2(N);
    localparam int unsigned DW = $clog2(2 * N);
    localparam int unsigned EW = SCORE_W + 2;

    localparam logic [DW-1:0]        DLAST   = DW'(2 * N - 2);
    localparam logic signed [EW-1:0] MATCH_S = EW'(MATCH);
    localparam logic signed [EW-1:0] MISS_S  = EW'(MISMATCH);
    localparam logic signed [EW-1:0] GAP_S   = EW'(GAP);
    localparam logic signed [EW-1:0] MAXV_S  = EW'(2 ** SCORE_W - 1);

    typedef enum logic {IDLE, COMPUTE} state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          d_q, d_d;
    logic                   busy_d, valid_d;
    logic                   load_c, done_c;

    logic [2*N-1:0]         s1_q, s2_q;
    logic [N*SCORE_W-1:0]   frow_q, fcol_q;
    logic [SCORE_W-1:0]     diag_q;
    logic [TILE_W-1:0]      tile_q;

    logic [SCORE_W-1:0]     h_q    [N][N];
    logic [SCORE_W-1:0]     cell_c [N][N];
`ifdef SW_DIR_EN
    logic [1:0]             dir_q  [N][N];
    logic [1:0]             dir_c  [N][N];
`endif

    logic [SCORE_W-1:0]     max_val_q, mx_val;
    logic [RW-1:0]          max_row_q, max_col_q, mx_row, mx_col;

    // Per-cell recurrence; neighbours come from the two previous diagonals or the latched boundaries
    for (genvar gi = 0; gi < NI; gi++) begin : g_row
        for (genvar gj = 0; gj < NI; gj++) begin : g_col
            logic [SCORE_W-1:0]    up_v, lf_v, dg_v, cell_v;
            logic signed [EW-1:0]  e_dg, e_up, e_lf, best;
`ifdef SW_DIR_EN
            logic [1:0]            dir_v;
`endif
            if (gi == 0) begin : g_up_b
                assign up_v = frow_q[SCORE_W*gj +: SCORE_W];
            end else begin : g_up_h
                assign up_v = h_q[gi-1][gj];
            end
            if (gj == 0) begin : g_lf_b
                assign lf_v = fcol_q[SCORE_W*gi +: SCORE_W];
            end else begin : g_lf_h
                assign lf_v = h_q[gi][gj-1];
            end
            if (gi == 0 && gj == 0) begin : g_dg_c
                assign dg_v = diag_q;
            end else if (gi == 0) begin : g_dg_r
                assign dg_v = frow_q[SCORE_W*(gj-1) +: SCORE_W];
            end else if (gj == 0) begin : g_dg_l
                assign dg_v = fcol_q[SCORE_W*(gi-1) +: SCORE_W];
            end else begin : g_dg_h
                assign dg_v = h_q[gi-1][gj-1];
            end

            // Saturating max of the three candidates; ties favour diagonal, then up
            always_comb begin
                e_dg = $signed(EW'(dg_v)) +
                       ((s1_q[2*gi +: 2] == s2_q[2*gj +: 2]) ? MATCH_S : -MISS_S);
                e_up = $signed(EW'(up_v)) - GAP_S;
                e_lf = $signed(EW'(lf_v)) - GAP_S;
                best = e_dg;
`ifdef SW_DIR_EN
                dir_v = 2'b01;
`endif
                if (e_up > best) begin
                    best = e_up;
`ifdef SW_DIR_EN
                    dir_v = 2'b10;
`endif
                end
                if (e_lf > best) begin
                    best = e_lf;
`ifdef SW_DIR_EN
                    dir_v = 2'b11;
`endif
                end
                if (best <= 0) begin
                    cell_v = '0;
`ifdef SW_DIR_EN
                    dir_v = 2'b00;
`endif
                end else if (best > MAXV_S) begin
                    cell_v = MAXV_S[SCORE_W-1:0];
                end else begin
                    cell_v = best[SCORE_W-1:0];
                end
            end

            assign cell_c[gi][gj] = cell_v;
`ifdef SW_DIR_EN
            assign dir_c[gi][gj] = dir_v;
`endif
        end
    end

    // Running maximum over the current diagonal, ascending row so ties keep the earliest cell
    always_comb begin
        mx_val = max_val_q;
        mx_row = max_row_q;
        mx_col = max_col_q;
        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < NI; j++) begin
                if ((int'(d_q) == i + j) && (cell_c[i][j] > mx_val)) begin
                    mx_val = cell_c[i][j];
                    mx_row = RW'(i);
                    mx_col = RW'(j);
                end
            end
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        busy_d  = busy;
        valid_d = 1'b0;
        load_c  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    d_d     = '0;
                    busy_d  = 1'b1;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                d_d = d_q + DW'(1);
                if (d_q == DLAST) begin
                    done_c  = 1'b1;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, operand latch, running maximum and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            d_q         <= '0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            frow_q      <= '0;
            fcol_q      <= '0;
            diag_q      <= '0;
            tile_q      <= '0;
            max_val_q   <= '0;
            max_row_q   <= '0;
            max_col_q   <= '0;
            lastRow     <= '0;
            lastCol     <= '0;
            diagonalOut <= '0;
            maxValue    <= '0;
            maxRow      <= '0;
            maxCol      <= '0;
            tileNumOut  <= '0;
`ifdef SW_DIR_EN
            dirMatrix   <= '0;
`endif
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            busy    <= busy_d;
            valid   <= valid_d;
            if (load_c) begin
                s1_q      <= S1;
                s2_q      <= S2;
                frow_q    <= firstRow;
                fcol_q    <= firstCol;
                diag_q    <= diagonalCell;
                tile_q    <= tileNum;
                max_val_q <= '0;
                max_row_q <= '0;
                max_col_q <= '0;
            end else if (state_q == COMPUTE) begin
                max_val_q <= mx_val;
                max_row_q <= mx_row;
                max_col_q <= mx_col;
            end
            if (done_c) begin
                for (int k = 0; k < NI; k++) begin
                    lastRow[SCORE_W*k +: SCORE_W] <= (k == NI - 1) ? cell_c[NI-1][k] : h_q[NI-1][k];
                    lastCol[SCORE_W*k +: SCORE_W] <= (k == NI - 1) ? cell_c[k][NI-1] : h_q[k][NI-1];
                end
                diagonalOut <= cell_c[NI-1][NI-1];
                maxValue    <= mx_val;
                maxRow      <= mx_row;
                maxCol      <= mx_col;
                tileNumOut  <= tile_q;
`ifdef SW_DIR_EN
                for (int i = 0; i < NI; i++) begin
                    for (int j = 0; j < NI; j++) begin
                        dirMatrix[2*(i*NI+j) +: 2] <= (int'(d_q) == i + j) ? dir_c[i][j] : dir_q[i][j];
                    end
                end
`endif
            end
        end
    end

    // Score array: each cell is written once, on the cycle its diagonal is evaluated
    always_ff @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < NI; j++) begin
                if (reset) begin
                    h_q[i][j] <= '0;
`ifdef SW_DIR_EN
                    dir_q[i][j] <= 2'b00;
`endif
                end else if ((state_q == COMPUTE) && (int'(d_q) == i + j)) begin
                    h_q[i][j] <= cell_c[i][j];
`ifdef SW_DIR_EN
                    dir_q[i][j] <= dir_c[i][j];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_sw_tile_solver_param.sv
// Self-checking bench for sw_tile_solver_param at default parameters.
module tb_sw_tile_solver_param;

    localparam int N  = 16;
    localparam int SW = 8;
    localparam int TW = 4;
    localparam int RW = 4;
    localparam int CW = N * SW;
    localparam int NV = 11;

    typedef struct {
        logic [2*N-1:0]  s1;
        logic [2*N-1:0]  s2;
        logic [CW-1:0]   frow;
        logic [CW-1:0]   fcol;
        logic [SW-1:0]   dg;
        logic [TW-1:0]   tile;
        logic [CW-1:0]   exp_lr;
        logic [CW-1:0]   exp_lc;
        logic [SW-1:0]   exp_dg;
        logic [SW-1:0]   exp_mx;
        logic [RW-1:0]   exp_r;
        logic [RW-1:0]   exp_c;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset, start;
    logic [TW-1:0]   tileNum;
    logic [2*N-1:0]  S1, S2;
    logic [CW-1:0]   firstRow, firstCol;
    logic [SW-1:0]   diagonalCell;
    logic [CW-1:0]   lastRow, lastCol;
    logic [SW-1:0]   diagonalOut, maxValue;
    logic [RW-1:0]   maxRow, maxCol;
    logic [TW-1:0]   tileNumOut;
    logic            busy, valid;
`ifdef SW_DIR_EN
    logic [2*N*N-1:0] dirMatrix;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    sw_tile_solver_param dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .tileNum      (tileNum),
        .S1           (S1),
        .S2           (S2),
        .firstRow     (firstRow),
        .firstCol     (firstCol),
        .diagonalCell (diagonalCell),
        .lastRow      (lastRow),
        .lastCol      (lastCol),
        .diagonalOut  (diagonalOut),
        .maxValue     (maxValue),
        .maxRow       (maxRow),
        .maxCol       (maxCol),
        .tileNumOut   (tileNumOut),
        .busy         (busy),
        .valid        (valid)
`ifdef SW_DIR_EN
        ,
        .dirMatrix    (dirMatrix)
`endif
    );

    task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: full-matrix evaluation in row-major order, then diagonal-order max scan
    task automatic model(inout vec_t v);
        int h [N+1][N+1];
        int s, b, mv, j;
        h[0][0] = int'(v.dg);
        for (int k = 0; k < N; k++) begin
            h[0][k+1] = int'(v.frow[SW*k +: SW]);
            h[k+1][0] = int'(v.fcol[SW*k +: SW]);
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                s = (v.s1[2*r +: 2] == v.s2[2*c +: 2]) ? 2 : -1;
                b = 0;
                if (h[r][c] + s > b)   b = h[r][c] + s;
                if (h[r][c+1] - 1 > b) b = h[r][c+1] - 1;
                if (h[r+1][c] - 1 > b) b = h[r+1][c] - 1;
                if (b > 255) b = 255;
                h[r+1][c+1] = b;
            end
        end
        for (int k = 0; k < N; k++) begin
            v.exp_lr[SW*k +: SW] = SW'(h[N][k+1]);
            v.exp_lc[SW*k +: SW] = SW'(h[k+1][N]);
        end
        v.exp_dg = SW'(h[N][N]);
        mv = 0; v.exp_r = '0; v.exp_c = '0;
        for (int d = 0; d <= 2*N-2; d++) begin
            for (int r = 0; r < N; r++) begin
                j = d - r;
                if (j >= 0 && j < N && h[r+1][j+1] > mv) begin
                    mv = h[r+1][j+1];
                    v.exp_r = RW'(r);
                    v.exp_c = RW'(j);
                end
            end
        end
        v.exp_mx = SW'(mv);
    endtask

    task automatic drive(input vec_t v);
        S1 = v.s1; S2 = v.s2; firstRow = v.frow; firstCol = v.fcol;
        diagonalCell = v.dg; tileNum = v.tile;
    endtask

    task automatic wait_valid(input int lat0, output int lat);
        lat = lat0;
        while (!valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_job(input vec_t v, output int lat);
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", CW'(busy), CW'(1));
        wait_valid(0, lat);
    endtask

    task automatic check_out(input vec_t v, input string tag);
        chk({tag, ":diagOut"}, CW'(diagonalOut), CW'(v.exp_dg));
        chk({tag, ":maxValue"}, CW'(maxValue), CW'(v.exp_mx));
        chk({tag, ":maxRow"}, CW'(maxRow), CW'(v.exp_r));
        chk({tag, ":maxCol"}, CW'(maxCol), CW'(v.exp_c));
        chk({tag, ":lastRow"}, lastRow, v.exp_lr);
        chk({tag, ":lastCol"}, lastCol, v.exp_lc);
        chk({tag, ":tileOut"}, CW'(tileNumOut), CW'(v.tile));
        chk({tag, ":busy"}, CW'(busy), CW'(0));
    endtask

    initial begin
        int lat;
        int bad;
        vec_t va, vb;

        // Directed vectors with hand-derived expectations
        vecs[0] = '{default: '0};
        vecs[0].tile = 4'd3;
        model(vecs[0]);
        vecs[0].exp_dg = 8'd32; vecs[0].exp_mx = 8'd32;
        vecs[0].exp_r = 4'd15;  vecs[0].exp_c = 4'd15;
        for (int k = 0; k < N; k++) begin
            vecs[0].exp_lr[SW*k +: SW] = SW'(2 * (k + 1));
            vecs[0].exp_lc[SW*k +: SW] = SW'(2 * (k + 1));
        end

        vecs[1] = '{default: '0};
        vecs[1].s2 = 32'h5555_5555;
        vecs[1].tile = 4'd7;

        vecs[2] = '{default: '0};
        vecs[2].dg = 8'd250;
        vecs[2].tile = 4'd9;
        for (int k = 0; k < N; k++) begin
            vecs[2].frow[SW*k +: SW] = 8'd250;
            vecs[2].fcol[SW*k +: SW] = 8'd250;
        end
        model(vecs[2]);
        vecs[2].exp_dg = 8'd255; vecs[2].exp_mx = 8'd255;
        vecs[2].exp_r = 4'd2;    vecs[2].exp_c = 4'd2;

        // Randomised vectors; the last one uses high boundaries to exercise saturation
        for (int i = 3; i < NV; i++) begin
            vecs[i].s1   = $urandom();
            vecs[i].s2   = vecs[i].s1 ^ ($urandom() & $urandom());
            vecs[i].tile = TW'($urandom_range(0, 15));
            vecs[i].dg   = SW'((i == NV-1) ? $urandom_range(200, 255) : $urandom_range(0, 30));
            for (int k = 0; k < N; k++) begin
                vecs[i].frow[SW*k +: SW] = SW'((i == NV-1) ? $urandom_range(200, 255) : $urandom_range(0, 30));
                vecs[i].fcol[SW*k +: SW] = SW'((i == NV-1) ? $urandom_range(200, 255) : $urandom_range(0, 30));
            end
            model(vecs[i]);
        end

        // Reset state
        reset = 1'b1; start = 1'b0;
        drive(vecs[1]);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst:busy", CW'(busy), CW'(0));
        chk("rst:valid", CW'(valid), CW'(0));
        chk("rst:maxValue", CW'(maxValue), CW'(0));
        chk("rst:lastRow", lastRow, CW'(0));
        chk("rst:tileOut", CW'(tileNumOut), CW'(0));

        // Table-driven jobs
        for (int i = 0; i < NV; i++) begin
            run_job(vecs[i], lat);
            chk($sformatf("vec%0d:latency", i), CW'(lat), CW'(31));
            check_out(vecs[i], $sformatf("vec%0d", i));
            @(posedge clk); #1;
            chk($sformatf("vec%0d:validPulse", i), CW'(valid), CW'(0));
        end

        // Start while busy is ignored
        va = vecs[0]; vb = vecs[1];
        @(negedge clk);
        drive(va); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 drive(vb); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_valid(5, lat);
        chk("ignore:latency", CW'(lat), CW'(31));
        check_out(va, "ignore");

        // Reset mid-computation aborts the job and clears outputs
        @(negedge clk);
        drive(va); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("abort:busy", CW'(busy), CW'(0));
        chk("abort:valid", CW'(valid), CW'(0));
        chk("abort:maxValue", CW'(maxValue), CW'(0));
        chk("abort:diagOut", CW'(diagonalOut), CW'(0));
        chk("abort:lastCol", lastCol, CW'(0));
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) bad++;
        end
        chk("abort:noValid", CW'(bad), CW'(0));
        run_job(va, lat);
        chk("abort:rerunLatency", CW'(lat), CW'(31));
        chk("abort:rerunMax", CW'(maxValue), CW'(32));

        // Back-to-back: start in the valid cycle, first results held until the second completes
        @(posedge clk); #1;
        va = vecs[5]; vb = vecs[6];
        run_job(va, lat);
        chk("b2b:latencyA", CW'(lat), CW'(31));
        check_out(va, "b2bA");
        drive(vb); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("b2b:busyB", CW'(busy), CW'(1));
        bad = 0;
        lat = 0;
        while (!valid && lat < 100) begin
            if (maxValue !== va.exp_mx || lastRow !== va.exp_lr || tileNumOut !== va.tile) bad++;
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b:held", CW'(bad), CW'(0));
        chk("b2b:latencyB", CW'(lat), CW'(31));
        check_out(vb, "b2bB");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
